// File: rtl/wb_arbiter_pkg.sv
// wb_pkg: shared widths and result-source encoding for the write-back arbiter
package wb_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_REG_AW = 5;
  localparam int STARVE_CNT_W = 3;
  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: requester handshakes and register-file write port
interface wb_arbiter_if import wb_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
);
  logic alu_valid;
  logic alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic mem_valid;
  logic mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic result_src;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, result_src
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, result_src
  );
endinterface

// File: rtl/wb_arbiter_starve_arb.sv
// wb_starve_arb: load-priority grant with a bounded ALU starvation guarantee
module wb_starve_arb import wb_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic grant_alu,
  output logic grant_mem
);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  logic armed_q, armed_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  always_comb begin
    armed_d = 1'b1;
    grant_alu = armed_q && alu_valid && (!mem_valid || starve_cnt_q == LIMIT);
    grant_mem = armed_q && mem_valid && !grant_alu;
    starve_cnt_d = (grant_alu || !alu_valid) ? '0 :
                   grant_mem ? ((starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 1'b1) :
                   starve_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      armed_q <= armed_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between ALU and load return
module wb_arbiter import wb_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  wb_arbiter_if.slave bus
);
  logic grant_alu, grant_mem, grant;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  logic rf_we_q, rf_we_d, result_src_q, result_src_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  wb_starve_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(bus.alu_valid),
    .mem_valid(bus.mem_valid),
    .grant_alu(grant_alu),
    .grant_mem(grant_mem)
  );
  always_comb begin
    grant = grant_alu | grant_mem;
    sel_rd = grant_mem ? bus.mem_rd : bus.alu_rd;
    sel_data = grant_mem ? bus.mem_data : bus.alu_data;
    rf_we_d = grant && sel_rd != '0;
    rf_waddr_d = grant ? sel_rd : rf_waddr_q;
    rf_wdata_d = grant ? (rf_we_d ? sel_data : '0) : rf_wdata_q;
    result_src_d = grant ? (grant_mem ? RESULT_SRC_MEM : RESULT_SRC_ALU) : result_src_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      result_src_q <= RESULT_SRC_ALU;
    end else begin
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      result_src_q <= result_src_d;
    end
  end
  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rf_we = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.result_src = result_src_q;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single register-file write port between the ALU result path and the load-return path. It is needed once loads complete with variable latency while ALU results keep arriving. Loads have priority; a starvation counter guarantees the ALU a grant after a bounded number of consecutive load wins. The granted result is registered and driven to the register file together with a `result_src` tag, which uses the same encoding as the write-back mux select: 0 = ALU, 1 = memory.

## Interface
Parameters:
- `XLEN`, 32, data width
- `REG_AW`, 5, register address width
- `STARVE_LIMIT`, 4, maximum consecutive load grants while the ALU waits (legal range 1..7)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  REG_AW  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `mem_valid`  in  1  load data offered
- `mem_ready`  out  1  load data accepted this cycle
- `mem_rd`  in  REG_AW  load destination register
- `mem_data`  in  XLEN  load data
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  REG_AW  write address (registered)
- `rf_wdata`  out  XLEN  write data (registered)
- `result_src`  out  1  source of the last grant: 0 = ALU, 1 = mem (registered)

## Operation
- **Handshake:** a transfer occurs when `x_valid && x_ready`.
  - Requesters hold `valid`, `rd` and `data` stable until the transfer.
  - `valid` must not depend on `ready`.
  - `ready` may depend combinationally on both valids.
- **Arm flag:** an internal `armed` register is cleared by reset and set on the first rising edge after `rst_n` deasserts. Both readies are held at 0 while `armed` = 0.
- **Grant rules** (evaluated only when `armed` = 1):
  - Only one valid: that source is granted.
  - Both valid and `starve_cnt == STARVE_LIMIT`: ALU is granted.
  - Both valid otherwise: mem is granted.
  - Neither valid: no grant; both readies are 0.
  - At most one ready is high in any cycle.
- **`starve_cnt`** (3 bits, reset 0), updated each edge:
  - mem granted while `alu_valid` = 1: increment, saturating at `STARVE_LIMIT`.
  - ALU granted, or `alu_valid` = 0: clear to 0.
  - Otherwise: hold.
- **Write stage**, on the edge after a grant:
  - `rf_waddr` ← granted `rd`
  - `rf_wdata` ← granted data
  - `result_src` ← granted source
  - `rf_we` ← 1 if `rd` != 0
- **x0 write:** a grant with `rd == 0` still completes the handshake. The next cycle shows `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, and `result_src` updated.
- **No grant:** `rf_we` ← 0; `rf_waddr`, `rf_wdata` and `result_src` hold their previous values.
- **No output backpressure:** the register file accepts every write, so a grant is possible every cycle (sustained throughput 1 write/cycle).

## Timing
- **Reset values:** `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `result_src` = 0, `alu_ready` = 0, `mem_ready` = 0, `starve_cnt` = 0, `armed` = 0.
- **Reset assertion:** takes effect immediately and asynchronously. Readies drop at once; a transfer in flight that cycle is lost and the requester re-offers it after reset.
- **First grant:** no earlier than the second rising edge after `rst_n` deasserts (the first edge only sets `armed`).
- **Latency:** grant in cycle N produces `rf_we`/`rf_waddr`/`rf_wdata` valid in cycle N+1, for exactly one cycle unless another grant follows.
- **Back-to-back grants:** yield `rf_we` = 1 on consecutive cycles with the new address and data each cycle.
- **Saturation:** with both requesters permanently valid and `STARVE_LIMIT` = 4, the grant pattern repeats: mem ×4, ALU ×1.
- **`alu_valid` dropping:** when `alu_valid` drops, the counter clears the same edge, so a later ALU request restarts the count.

## Structure
- **Package `wb_pkg`:**
  - `XLEN`, `REG_AW` defaults
  - `RESULT_SRC_ALU` = 1'b0, `RESULT_SRC_MEM` = 1'b1
  - `STARVE_CNT_W` = 3
- **Sub-module `wb_starve_arb`:** contains the grant logic, `starve_cnt` and `armed`. Outputs `grant_alu` and `grant_mem`.
- **Top level:** holds the write-stage registers and the data/address select, steered by the grant rather than by an external select.

## Test plan
- **Reset:** hold `rst_n` = 0 with both valids high, then release → both readies stay 0 through the first edge after release; first grant is to mem at the second edge; all outputs are 0 during reset.
- **Single ALU request:** `alu_valid` = 1, `alu_rd` = 5, `alu_data` = 32'h12345678 → `alu_ready` = 1 the same cycle; next cycle `rf_we` = 1, `rf_waddr` = 5, `rf_wdata` = 32'h12345678, `result_src` = 0.
- **Contention:** both valid for 12 cycles, `mem_data` = 32'hABCDEF01, `alu_data` = 32'h11112222 → grant sequence M,M,M,M,A,M,M,M,M,A,M,M; `result_src` follows one cycle later.
- **x0 suppression:** `mem_rd` = 0, `mem_data` = 32'h33334444 → `mem_ready` = 1; next cycle `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `result_src` = 1.
- **Counter clear:** both valid for 3 cycles (3 mem grants), drop `alu_valid` for 1 cycle, then both valid again → 4 further mem grants occur before the ALU is granted.
- **Mid-operation reset:** assert `rst_n` = 0 in the cycle of a mem grant → `rf_we` = 0 immediately, no write appears, `starve_cnt` returns to 0.
